servo_pwm_driver: RTL
=====================

# servo_pwm_driver

Downstream consumer of the inverse-kinematics stage. Accepts the two 16-bit joint angles it produces, in degrees, through a valid/ready handshake. Converts each angle to a pulse width and drives two hobby-servo PWM outputs at a fixed frame rate. New angles are double-buffered and applied only at frame boundaries, so a pulse is never truncated or stretched mid-frame.

## Interface
Parameters:
- PERIOD_CYCLES, 2_000_000: clocks per PWM frame (20 ms at 100 MHz).
- MIN_PULSE, 100_000: pulse width in clocks for angle 0 (1 ms).
- STEP_CYCLES, 555: additional clocks per degree.
- ANGLE_MAX, 180: largest accepted angle; larger inputs are clamped to this value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- angle0  in  16  joint-0 angle, unsigned degrees.
- angle1  in  16  joint-1 angle, unsigned degrees.
- in_valid  in  1  angle0/angle1 are valid this cycle.
- in_ready  out  1  pending buffer is empty; a handshake is accepted when in_valid && in_ready.
- pwm0  out  1  servo 0 PWM.
- pwm1  out  1  servo 1 PWM.
- frame_start  out  1  one-cycle pulse on the first cycle of each enabled frame.
- enabled  out  1  at least one angle pair has been applied since reset.
- clamped  out  1  one-cycle pulse: the last accepted pair had an angle > ANGLE_MAX.

## Operation
- Frame counter `cnt`:
  - Width $clog2(PERIOD_CYCLES).
  - Free-running from 0 to PERIOD_CYCLES-1, then wraps to 0.
  - Runs whether or not the block is enabled.
- Pending buffer (`pend0`, `pend1`, `pend_full`):
  - On a handshake, store each clamped angle, min(angle_i, ANGLE_MAX), and set pend_full.
  - in_ready = !pend_full.
- Active widths `width0`, `width1`:
  - Loaded on the edge that wraps cnt from PERIOD_CYCLES-1 to 0, and only if pend_full was 1 before that edge.
  - width_i = MIN_PULSE + pend_i*STEP_CYCLES, computed in 32-bit unsigned arithmetic. No overflow is possible for legal parameters.
  - The same edge clears pend_full and sets enabled; enabled stays 1 until reset.
- Boundary cases:
  - A handshake on the wrap edge while pend_full=0 fills pending but is NOT applied that edge. It is applied at the following wrap.
  - While pend_full=1, in_ready=0. The producer must hold its data, and no handshake can coincide with a transfer.
- Outputs, all registered and computed from next-state values so they align with cnt:
  - pwm_i = enabled && (cnt < width_i).
  - frame_start = enabled && (cnt == 0).
- Widths and enabled are constant within a frame. Pulses start at cnt=0 and last exactly width_i cycles.
- Two states, implicit in `enabled`:
  - IDLE: outputs low, waiting for the first pair.
  - RUN: PWM active.
  - IDLE→RUN on the first transfer. There is no RUN→IDLE transition except reset.

## Timing
- Reset values:
  - cnt=0, pend_full=0, in_ready=1.
  - width0=width1=MIN_PULSE.
  - enabled=0, pwm0=pwm1=0, frame_start=0, clamped=0.
- Reset asserted at any point (including mid-pulse) forces all of the above immediately, without waiting for a clock. The pending pair is discarded.
- After reset deasserts, cnt advances from 0 on the first clock edge.
- Handshake-to-ready latency: in_ready falls the cycle after acceptance.
- Handshake-to-pulse latency: the first pulse using the new pair begins at the next cnt=0 after acceptance. This is at most PERIOD_CYCLES cycles later, or exactly PERIOD_CYCLES cycles when accepted on the wrap edge.
- in_ready returns to 1 on the cycle where cnt=0 after a transfer.
- clamped is high for exactly one cycle: the cycle after an accepting edge where either angle exceeded ANGLE_MAX.

## Test plan
All scenarios use PERIOD_CYCLES=100, MIN_PULSE=10, STEP_CYCLES=1, ANGLE_MAX=60.
- Release reset, no in_valid for 3 frames -> pwm0/pwm1/frame_start/enabled stay 0; in_ready stays 1; cnt wraps at 99.
- Send (0, 60) at cnt=20 -> in_ready 0 from cnt=21 to 99; at cnt=0: frame_start=1, enabled=1, in_ready=1; pwm0 high 10 cycles, pwm1 high 70 cycles; repeats every frame.
- Send (90, 30) -> clamped pulses once; pwm0 width 70, pwm1 width 40 from the next frame.
- Offer (20, 20) at cnt=10, then hold in_valid with (40, 5) -> second pair stalls until cnt=0; widths are 30/30 for one frame, then 50/15; widths never change mid-frame.
- Handshake (5, 5) on the cnt=99 edge with pending empty -> the next frame keeps the old widths; widths 15/15 appear one frame later.
- Assert reset at cnt=30 of a 70-cycle pulse -> pwm1 drops with no clock edge; enabled=0, in_ready=1; after release there are no pulses until a new pair is accepted and a wrap occurs.

Source files
------------

// File: rtl/servo_pwm_driver.sv
// Two-channel hobby-servo PWM driver: angle pairs arrive over valid/ready,
// wait in a pending buffer, and become the active pulse widths only at frame wrap.
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int MIN_PULSE     = 100_000,
  parameter int STEP_CYCLES   = 555,
  parameter int ANGLE_MAX     = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] angle0,
  input  logic [15:0] angle1,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        pwm0,
  output logic        pwm1,
  output logic        frame_start,
  output logic        enabled,
  output logic        clamped
);

  localparam int              NUM_LANES = 2;
  localparam int              CW        = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [15:0]     AMAX      = 16'(ANGLE_MAX);
  localparam logic [31:0]     WMIN      = 32'(MIN_PULSE);
  localparam logic [31:0]     WSTEP     = 32'(STEP_CYCLES);

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           pend_full_q, pend_full_d;
  logic                           enabled_q, enabled_d;
  logic                           frame_start_q, frame_start_d;
  logic                           clamped_q, clamped_d;
  logic [NUM_LANES-1:0][15:0]     angle_in;
  logic [NUM_LANES-1:0][15:0]     pend_q, pend_d;
  logic [NUM_LANES-1:0][31:0]     width_q, width_d;
  logic [NUM_LANES-1:0]           pwm_q, pwm_d;
  logic [NUM_LANES-1:0]           over;
  logic                           wrap, hs, xfer;

  assign angle_in = {angle1, angle0};
  assign in_ready = !pend_full_q;

  always_comb begin
    wrap          = (cnt_q == CNT_LAST);
    hs            = in_valid && !pend_full_q;
    // in_ready is low whenever a transfer can happen, so hs and xfer never coincide
    xfer          = wrap && pend_full_q;
    cnt_d         = wrap ? '0 : cnt_q + CW'(1);
    pend_full_d   = pend_full_q;
    if (xfer)    pend_full_d = 1'b0;
    else if (hs) pend_full_d = 1'b1;
    enabled_d     = enabled_q | xfer;
    frame_start_d = enabled_d && (cnt_d == '0);
    pend_d        = pend_q;
    width_d       = width_q;
    over          = '0;
    pwm_d         = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      over[i] = (angle_in[i] > AMAX);
      if (hs)   pend_d[i]  = over[i] ? AMAX : angle_in[i];
      if (xfer) width_d[i] = WMIN + 32'(pend_q[i]) * WSTEP;
      // outputs use next-state values so the registered pwm lines up with cnt
      pwm_d[i] = enabled_d && (32'(cnt_d) < width_d[i]);
    end
    clamped_d     = hs && (|over);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      pend_full_q   <= 1'b0;
      enabled_q     <= 1'b0;
      frame_start_q <= 1'b0;
      clamped_q     <= 1'b0;
      pend_q        <= '0;
      width_q       <= {NUM_LANES{WMIN}};
      pwm_q         <= '0;
    end else begin
      cnt_q         <= cnt_d;
      pend_full_q   <= pend_full_d;
      enabled_q     <= enabled_d;
      frame_start_q <= frame_start_d;
      clamped_q     <= clamped_d;
      pend_q        <= pend_d;
      width_q       <= width_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm0        = pwm_q[0];
  assign pwm1        = pwm_q[1];
  assign frame_start = frame_start_q;
  assign enabled     = enabled_q;
  assign clamped     = clamped_q;

endmodule
